// File: rtl/fsk_pkg.sv
// Shared FSK receive/transmit definitions: tracker states and default timing
// constants used by the divider, the tone period detector and the deframer.
package fsk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    TRACK = 2'd2
  } fsk_state_e;

  localparam int CNT_W_DEF       = 8;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int MIN_PERIOD_DEF  = 4;
  localparam int THRESH_DEF      = 24;
  localparam int TIMEOUT_DEF     = 255;

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchronizer for an asynchronous level, followed by a registered
// rising-edge pulse (one clk wide) on the synchronized signal.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   sync_prev;

  // NOTE: every flop here, including the synchronizer chain, is cleared by the
  // async reset so a level already high at release is reported as a fresh edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain     <= '0;
      sync_prev <= 1'b0;
      rise      <= 1'b0;
    end else begin
      chain     <= {chain[SYNC_STAGES-2:0], d};
      sync_prev <= chain[SYNC_STAGES-1];
      // Registered so the measurement strobe lands SYNC_STAGES+1 edges after sampling.
      rise      <= chain[SYNC_STAGES-1] & ~sync_prev;
    end
  end

endmodule

// File: rtl/tone_period_detect.sv
// Measures the period of a square-wave FSK tone in clk cycles, classifies it as
// mark/space and tracks lock, dropping it after TIMEOUT cycles without an edge.
module tone_period_detect
  import fsk_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int MIN_PERIOD  = MIN_PERIOD_DEF,
  parameter int THRESH      = THRESH_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tone_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             bit_out,
  output logic             lock,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] THR_C = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] TMO_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  fsk_state_e       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             rise;
  logic             accept;
  logic             expire;

  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (tone_in),
    .rise (rise)
  );

  // NOTE: every signal driven here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    expire  = 1'b0;
    case (state)
      IDLE: begin
        if (rise) state_n = ARMED;
      end
      ARMED, TRACK: begin
        // A rise always beats expiry; a glitch rise neither accepts nor expires.
        if (rise) begin
          if (cnt >= MIN_C) begin
            accept  = 1'b1;
            state_n = TRACK;
          end
        end else if (cnt == TMO_C) begin
          expire  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (accept || (state == IDLE && rise)) begin
      cnt_n = ONE_C;
    end else if (cnt != TMO_C) begin
      cnt_n = cnt + ONE_C;
    end else begin
      cnt_n = cnt;
    end
  end

  // NOTE: state and output registers use non-blocking assignments so every flop
  // samples the pre-edge values computed above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      bit_out      <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      period_valid <= accept;
      timeout      <= expire;
      if (accept) begin
        period  <= cnt;
        bit_out <= (cnt < THR_C);
      end
    end
  end

  assign lock = (state == TRACK);

endmodule

// File: tb/tb_tone_period_detect.sv
// Directed bench for tone_period_detect: drives tone patterns on negedges and
// checks logged strobes against hand-computed periods, classes and timing.
module tb_tone_period_detect;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tone_in = 1'b0;
  logic [7:0] period;
  logic       period_valid;
  logic       bit_out;
  logic       lock;
  logic       timeout;

  tone_period_detect dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tone_in     (tone_in),
    .period      (period),
    .period_valid(period_valid),
    .bit_out     (bit_out),
    .lock        (lock),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int period;
    int bit_v;
    int lock;
  } ev_t;

  ev_t pv_q[$];
  ev_t to_q[$];
  int  overlap = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (period_valid) pv_q.push_back('{cyc, int'(period), int'(bit_out), int'(lock)});
      if (timeout) to_q.push_back('{cyc, int'(period), int'(bit_out), int'(lock)});
      if (period_valid && timeout) overlap++;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int rise_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive level v for n cycles; remember the cycle a rising edge was driven.
  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (v && !tone_in) rise_cyc = cyc;
      tone_in = v;
    end
  endtask

  task automatic tone(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      hold(1'b1, hi);
      hold(1'b0, lo);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_period"}, period, 0);
    check({tag, "_valid"}, period_valid, 0);
    check({tag, "_bit"}, bit_out, 0);
    check({tag, "_lock"}, lock, 0);
    check({tag, "_timeout"}, timeout, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: observed no finish expected finish within 2ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a_cyc;

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: steady 32-clk tone
    pv_q.delete();
    tone(16, 16, 4);
    check("t1_count", pv_q.size(), 3);
    for (int i = 0; i < pv_q.size(); i++) begin
      check("t1_period", pv_q[i].period, 32);
      check("t1_bit", pv_q[i].bit_v, 0);
    end
    if (pv_q.size() == 3) begin
      check("t1_spacing", pv_q[2].cyc - pv_q[1].cyc, 32);
      check("t1_latency", pv_q[2].cyc, rise_cyc + 4);
    end
    check("t1_lock", lock, 1);

    // 2: 16-clk tone, then back to 32
    pv_q.delete();
    tone(8, 8, 4);
    check("t2_count16", pv_q.size(), 4);
    if (pv_q.size() == 4) begin
      check("t2_p16_a", pv_q[2].period, 16);
      check("t2_p16_b", pv_q[3].period, 16);
      check("t2_bit16", pv_q[3].bit_v, 1);
    end
    pv_q.delete();
    tone(16, 16, 3);
    check("t2_count32", pv_q.size(), 3);
    if (pv_q.size() == 3) begin
      check("t2_partial_in_range", (pv_q[0].period >= 16 && pv_q[0].period <= 32), 1);
      check("t2_p32", pv_q[2].period, 32);
      check("t2_bit32", pv_q[2].bit_v, 0);
    end

    // 3: 2-clk notch 3 clk after an accepted edge is rejected
    pv_q.delete();
    hold(1'b1, 1);
    hold(1'b0, 2);
    hold(1'b1, 13);
    hold(1'b0, 16);
    tone(16, 16, 1);
    check("t3_count", pv_q.size(), 2);
    if (pv_q.size() == 2) begin
      check("t3_p0", pv_q[0].period, 32);
      check("t3_p1", pv_q[1].period, 32);
      check("t3_spacing", pv_q[1].cyc - pv_q[0].cyc, 32);
    end

    // 4: tone stops -> timeout 255 clk after the last accept, then relock
    a_cyc = (pv_q.size() > 0) ? pv_q[pv_q.size()-1].cyc : cyc;
    to_q.delete();
    for (int i = 0; i < 400 && to_q.size() == 0; i++) @(negedge clk);
    check("t4_timeout_seen", to_q.size(), 1);
    if (to_q.size() >= 1) begin
      check("t4_timeout_cyc", to_q[0].cyc, a_cyc + 255);
      check("t4_lock_at_timeout", to_q[0].lock, 0);
      check("t4_period_held", to_q[0].period, 32);
    end
    repeat (20) @(negedge clk);
    check("t4_single_timeout", to_q.size(), 1);
    check("t4_unlocked", lock, 0);
    pv_q.delete();
    tone(16, 16, 2);
    check("t4_relock_count", pv_q.size(), 1);
    if (pv_q.size() == 1) begin
      check("t4_relock_period", pv_q[0].period, 32);
      check("t4_relock_cyc", pv_q[0].cyc, rise_cyc + 4);
    end
    check("t4_relock", lock, 1);

    // 5: reset mid-period while locked, tone high at release
    hold(1'b1, 16);
    hold(1'b0, 8);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("t5_reset");
    tone_in = 1'b1;
    repeat (3) @(negedge clk);
    pv_q.delete();
    rst_n = 1'b1;
    hold(1'b1, 15);
    hold(1'b0, 16);
    tone(16, 16, 1);
    check("t5_count", pv_q.size(), 1);
    if (pv_q.size() == 1) begin
      check("t5_period", pv_q[0].period, 32);
      check("t5_cyc", pv_q[0].cyc, rise_cyc + 4);
    end

    // 6: edge arrives exactly when cnt reaches TIMEOUT
    pv_q.delete();
    to_q.delete();
    tone(128, 127, 3);
    check("t6_count", pv_q.size(), 3);
    if (pv_q.size() == 3) begin
      check("t6_p255_a", pv_q[1].period, 255);
      check("t6_p255_b", pv_q[2].period, 255);
      check("t6_bit", pv_q[2].bit_v, 0);
    end
    check("t6_no_timeout", to_q.size(), 0);
    check("t6_lock", lock, 1);

    // 7: MIN_PERIOD and THRESH boundaries: periods 4, 24, 23
    pv_q.delete();
    hold(1'b1, 2);
    hold(1'b0, 2);
    hold(1'b1, 12);
    hold(1'b0, 12);
    hold(1'b1, 12);
    hold(1'b0, 11);
    hold(1'b1, 1);
    hold(1'b0, 8);
    check("t7_count", pv_q.size(), 4);
    if (pv_q.size() == 4) begin
      check("t7_p4", pv_q[1].period, 4);
      check("t7_b4", pv_q[1].bit_v, 1);
      check("t7_p24", pv_q[2].period, 24);
      check("t7_b24", pv_q[2].bit_v, 0);
      check("t7_p23", pv_q[3].period, 23);
      check("t7_b23", pv_q[3].bit_v, 1);
    end

    check("no_valid_timeout_overlap", overlap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
